instr_decode_stage: RTL

- Pipelined decode stage between the fetch queue and the execute stage of the core.
- Accepts raw 32-bit instruction words over a valid/ready handshake and splits them into opcode, register indices and sign-extended immediate.
- Produces control strobes and presents one registered decoded bundle downstream.
- Contains a 1-entry skid buffer so that in_ready never depends combinationally on out_ready.
- Supports flush (branch redirect) and illegal-opcode flagging.

---
 rtl/instr_decode_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// Decode stage: splits raw instruction words into opcode, register indices,
// sign-extended immediate and control strobes. Holds one registered bundle
// plus a one-entry skid register, so in_ready comes only from local state.
module instr_decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [REG_AW-1:0] out_ra,
  output logic [REG_AW-1:0] out_rb,
  output logic [REG_AW-1:0] out_rc,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  dec_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic [XLEN-1:0]   imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } bundle_t;

  state_t           state_reg, state_next;
  bundle_t          or_reg, sk_reg, dec;
  logic             rdy_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_xfer, out_xfer;
  logic             load_or_dec, load_or_sk, load_sk;

  assign in_ready = rdy_reg;
  assign out_valid = (state_reg != EMPTY);
  assign in_xfer  = in_valid && rdy_reg;
  assign out_xfer = out_valid && out_ready;

  // Combinational decode of the incoming word; fields unused by an opcode stay 0
  always_comb begin
    dec    = '0;
    dec.op = in_instr[31:28];
    case (in_instr[31:28])
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        dec.ra        = in_instr[27:23];
        dec.rb        = in_instr[22:18];
        dec.rc        = in_instr[17:13];
        dec.reg_write = 1'b1;
      end
      4'd7: begin // LW: rb field is reused as the upper offset bits
        dec.ra        = in_instr[27:23];
        dec.rc        = in_instr[17:13];
        dec.imm       = {{(XLEN-18){in_instr[22]}}, in_instr[22:18], in_instr[12:0]};
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      4'd8: begin // SW
        dec.ra        = in_instr[27:23];
        dec.rb        = in_instr[22:18];
        dec.imm       = {{(XLEN-18){in_instr[17]}}, in_instr[17:0]};
        dec.mem_write = 1'b1;
      end
      4'd9, 4'd10, 4'd11: begin // BEQ / BLT / BLE
        dec.ra     = in_instr[27:23];
        dec.rb     = in_instr[22:18];
        dec.imm    = {{(XLEN-18){in_instr[17]}}, in_instr[17:0]};
        dec.branch = 1'b1;
      end
      4'd12: begin // JMP
        dec.imm  = {{(XLEN-28){in_instr[27]}}, in_instr[27:0]};
        dec.jump = 1'b1;
      end
      4'd13: begin // NOP: everything stays zero
      end
      default: begin // opcodes 14/15 still travel downstream so execute can trap
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Next-state and register-load selection for the output/skid pair
  always_comb begin
    state_next  = state_reg;
    load_or_dec = 1'b0;
    load_or_sk  = 1'b0;
    load_sk     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next  = ONE;
            load_or_dec = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_or_dec = 1'b1;
          end else if (in_xfer) begin
            state_next = FULL;
            load_sk    = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next = ONE;
            load_or_sk = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State, bundle storage, registered ready and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      or_reg    <= '0;
      sk_reg    <= '0;
      rdy_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rdy_reg   <= (state_next != FULL);
      if (out_xfer) cnt_reg <= cnt_reg + CNT_W'(1);
      if (load_or_dec) or_reg <= dec;
      else if (load_or_sk) or_reg <= sk_reg;
      if (load_sk) sk_reg <= dec;
    end
  end

  assign out_op        = or_reg.op;
  assign out_ra        = or_reg.ra;
  assign out_rb        = or_reg.rb;
  assign out_rc        = or_reg.rc;
  assign out_imm       = or_reg.imm;
  assign out_reg_write = or_reg.reg_write;
  assign out_mem_read  = or_reg.mem_read;
  assign out_mem_write = or_reg.mem_write;
  assign out_branch    = or_reg.branch;
  assign out_jump      = or_reg.jump;
  assign out_illegal   = or_reg.illegal;
  assign dec_count     = cnt_reg;

endmodule
